ram2p_fifo_ctrl: RTL and testbench

Single-clock byte FIFO controller wrapped around the 136x8 two-port RAM macro. Port A of the RAM is the write side and port B is the read side. A valid/ready producer interface feeds the RAM. A show-ahead (first-word-fall-through) consumer interface drains it through a 2-entry output buffer that hides the RAM's one-cycle registered read. Sits directly upstream of and around the RAM instance; RAM ck_a and ck_b are both driven from ck.

---
 rtl/ram2p_fifo_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_ram2p_fifo_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram2p_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram2p_fifo_ctrl
// Purpose  : Single-clock byte FIFO controller around a 136x8 two-port RAM.
//            Port A of the RAM is the write side and port B the read side.
//            Producers use a valid/ready interface. Consumers see a
//            show-ahead (first-word-fall-through) interface, which is drained
//            through a 2-entry register buffer. The buffer hides the RAM's
//            one-cycle registered read.
// Optional : `define RAM2P_FIFO_AF_EN adds the registered almost_full output
//            and the AF_THRESH parameter.
// Ports    : ck                clock, all state on posedge
//            rst_n             synchronous active-low reset
//            in_valid/in_data  producer byte, accepted when in_ready
//            in_ready          FIFO can take in_data this cycle
//            out_valid/out_data head-of-FIFO byte, popped when out_ready
//            out_ready         consumer takes out_data this cycle
//            level             bytes held (RAM + in flight + buffer), registered
//            almost_full       level >= AF_THRESH, registered (optional)
//            ram_*_a           RAM write port (address, enable, write, data)
//            ram_*_b           RAM read port (address, enable, write=0, oe=1,
//                              read data returned one cycle after enable)
// Revision : 1.0  initial release
// ============================================================================
module ram2p_fifo_ctrl #(
    parameter int DEPTH = 136,
    parameter int AW    = 8,
    parameter int DW    = 8
`ifdef RAM2P_FIFO_AF_EN
    ,
    parameter int AF_THRESH = 128
`endif
) (
    input  logic          ck,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [8:0]    level,
`ifdef RAM2P_FIFO_AF_EN
    output logic          almost_full,
`endif
    output logic [AW-1:0] ram_adr_a,
    output logic          ram_ena_a,
    output logic          ram_wri_a,
    output logic [DW-1:0] ram_wda_a,
    output logic [AW-1:0] ram_adr_b,
    output logic          ram_ena_b,
    output logic          ram_wri_b,
    output logic          ram_oe_b,
    input  logic [DW-1:0] ram_rda_b
);

    localparam int            CW          = 9;
    localparam logic [AW-1:0] c_PTR_LAST  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] c_DEPTH_CNT = CW'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_ram_cnt;     // words resident in the RAM, not yet read
    logic          r_rd_pend;     // a read was issued last edge; data is on ram_rda_b now
    logic [DW-1:0] r_buf_head;
    logic [DW-1:0] r_buf_tail;
    logic [1:0]    r_buf_cnt;
    logic [CW-1:0] r_level;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic          w_in_ready;
    logic          w_push;
    logic          w_pop;
    logic [2:0]    w_buf_occ;
    logic          w_rd_issue;
    logic [AW-1:0] w_wptr_nxt;
    logic [AW-1:0] w_rptr_nxt;
    logic [CW-1:0] w_ram_cnt_nxt;
    logic [1:0]    w_buf_cnt_nxt;
    logic [DW-1:0] w_head_nxt;
    logic [DW-1:0] w_tail_nxt;
    logic [CW-1:0] w_level_nxt;

    always_comb begin
        w_in_ready = rst_n && (r_ram_cnt < c_DEPTH_CNT);
        w_push     = in_valid && w_in_ready;
        w_pop      = (r_buf_cnt != 2'd0) && out_ready;

        // Buffer slots committed after this edge: entries held plus the byte
        // in flight, minus the one leaving. The read is issued only if a slot
        // is still free once that byte lands. A pop implies buf_cnt > 0, so
        // this expression cannot underflow.
        w_buf_occ  = {1'b0, r_buf_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
        w_rd_issue = rst_n && (r_ram_cnt != '0) && (w_buf_occ < 3'd2);

        w_wptr_nxt = r_wptr;
        if (w_push) begin
            w_wptr_nxt = (r_wptr == c_PTR_LAST) ? '0 : r_wptr + AW'(1);
        end

        w_rptr_nxt = r_rptr;
        if (w_rd_issue) begin
            w_rptr_nxt = (r_rptr == c_PTR_LAST) ? '0 : r_rptr + AW'(1);
        end

        w_ram_cnt_nxt = r_ram_cnt;
        if (w_push && !w_rd_issue) begin
            w_ram_cnt_nxt = r_ram_cnt + CW'(1);
        end else if (!w_push && w_rd_issue) begin
            w_ram_cnt_nxt = r_ram_cnt - CW'(1);
        end

        // Buffer update. A capture (r_rd_pend) always lands behind whatever
        // entry survives the pop, which keeps the bytes in order.
        w_buf_cnt_nxt = r_buf_cnt + {1'b0, r_rd_pend} - {1'b0, w_pop};
        w_head_nxt    = r_buf_head;
        w_tail_nxt    = r_buf_tail;
        case ({r_rd_pend, w_pop})
            2'b10: begin
                if (r_buf_cnt == 2'd0) begin
                    w_head_nxt = ram_rda_b;
                end else begin
                    w_tail_nxt = ram_rda_b;
                end
            end
            2'b11: begin
                if (r_buf_cnt == 2'd1) begin
                    w_head_nxt = ram_rda_b;
                end else begin
                    w_head_nxt = r_buf_tail;
                    w_tail_nxt = ram_rda_b;
                end
            end
            2'b01: begin
                // Popping the last entry leaves head untouched so out_data
                // keeps showing the last byte delivered.
                if (r_buf_cnt == 2'd2) begin
                    w_head_nxt = r_buf_tail;
                end
            end
            default: begin
            end
        endcase

        w_level_nxt = w_ram_cnt_nxt + CW'(w_rd_issue) + CW'(w_buf_cnt_nxt);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_cnt  <= '0;
            r_rd_pend  <= 1'b0;
            r_buf_head <= '0;
            r_buf_tail <= '0;
            r_buf_cnt  <= 2'd0;
            r_level    <= '0;
        end else begin
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
            r_ram_cnt  <= w_ram_cnt_nxt;
            r_rd_pend  <= w_rd_issue;
            r_buf_head <= w_head_nxt;
            r_buf_tail <= w_tail_nxt;
            r_buf_cnt  <= w_buf_cnt_nxt;
            r_level    <= w_level_nxt;
        end
    end

`ifdef RAM2P_FIFO_AF_EN
    // Computed from the next level so the flag changes on the same edge as level.
    localparam logic [CW-1:0] c_AF_LEVEL = CW'(AF_THRESH);
    logic r_almost_full;

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_level_nxt >= c_AF_LEVEL);
        end
    end

    assign almost_full = r_almost_full;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = (r_buf_cnt != 2'd0);
    assign out_data  = r_buf_head;
    assign level     = r_level;

    assign ram_adr_a = r_wptr;
    assign ram_ena_a = w_push;
    assign ram_wri_a = w_push;
    assign ram_wda_a = in_data;

    assign ram_adr_b = r_rptr;
    assign ram_ena_b = w_rd_issue;
    assign ram_wri_b = 1'b0;
    assign ram_oe_b  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_ram2p_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram2p_fifo_ctrl
// Purpose  : Directed self-checking bench for ram2p_fifo_ctrl with a
//            behavioural two-port RAM (registered read on port B).
// Revision : 1.0  initial release
// ============================================================================
module tb_ram2p_fifo_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          ck = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [8:0]    level;
`ifdef RAM2P_FIFO_AF_EN
    logic          almost_full;
`endif
    logic [AW-1:0] ram_adr_a;
    logic          ram_ena_a;
    logic          ram_wri_a;
    logic [DW-1:0] ram_wda_a;
    logic [AW-1:0] ram_adr_b;
    logic          ram_ena_b;
    logic          ram_wri_b;
    logic          ram_oe_b;
    logic [DW-1:0] ram_rda_b;

    always #5 ck = ~ck;

    ram2p_fifo_ctrl dut (
        .ck        (ck),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level),
`ifdef RAM2P_FIFO_AF_EN
        .almost_full (almost_full),
`endif
        .ram_adr_a (ram_adr_a),
        .ram_ena_a (ram_ena_a),
        .ram_wri_a (ram_wri_a),
        .ram_wda_a (ram_wda_a),
        .ram_adr_b (ram_adr_b),
        .ram_ena_b (ram_ena_b),
        .ram_wri_b (ram_wri_b),
        .ram_oe_b  (ram_oe_b),
        .ram_rda_b (ram_rda_b)
    );

    // Behavioural 2-port RAM: write on port A, registered read on port B.
    logic [DW-1:0] mem [0:255];
    always @(posedge ck) begin
        if (ram_ena_a && ram_wri_a) mem[ram_adr_a] <= ram_wda_a;
        if (ram_ena_b) ram_rda_b <= mem[ram_adr_b];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    int            w;
    int            refused;
    int            npop;
    int            npush;
    logic [7:0]    k_in;
    logic [7:0]    exp_out;
    logic [7:0]    bval;
    logic          pushed;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();

        // ---- reset state: interface gated while rst_n low ----
        in_valid = 1'b1;
        in_data  = 8'h11;
        #1;
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_ena_a",     ram_ena_a, 0);
        chk("rst_wri_a",     ram_wri_a, 0);
        chk("rst_ena_b",     ram_ena_b, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_level",     level,     0);
        chk("rst_out_data",  out_data,  0);
        chk("tie_wri_b",     ram_wri_b, 0);
        chk("tie_oe_b",      ram_oe_b,  1);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        #1;
        chk("idle_in_ready",  in_ready,  1);
        chk("idle_ena_a",     ram_ena_a, 0);
        chk("idle_ena_b",     ram_ena_b, 0);
        chk("idle_level",     level,     0);
        chk("idle_out_valid", out_valid, 0);

        // ---- single byte latency ----
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        #1;
        chk("one_ena_a", ram_ena_a, 1);
        chk("one_wri_a", ram_wri_a, 1);
        chk("one_adr_a", ram_adr_a, 0);
        chk("one_wda_a", ram_wda_a, 8'hA5);
        step();                     // E0
        in_valid = 1'b0;
        #1;
        chk("one_e0_valid", out_valid, 0);
        chk("one_e0_level", level,     1);
        chk("one_e0_ena_b", ram_ena_b, 1);
        chk("one_e0_adr_b", ram_adr_b, 0);
        step();                     // E1
        chk("one_e1_valid", out_valid, 0);
        step();                     // E2
        chk("one_e2_valid", out_valid, 1);
        chk("one_e2_data",  out_data,  8'hA5);
        step();                     // popped
        chk("one_pop_valid", out_valid, 0);
        chk("one_pop_level", level,     0);

        // ---- fill to full with the consumer stalled ----
        out_ready = 1'b0;
        refused   = 0;
        for (int i = 0; i < 138; i++) begin
            in_valid = 1'b1;
            bval     = i[7:0];
            in_data  = bval;
            #1;
            if (!in_ready) refused++;
            step();
        end
        chk("fill_refused", refused, 0);
        in_data = 8'hFF;
        #1;
        chk("full_in_ready", in_ready,  0);
        chk("full_ena_a",    ram_ena_a, 0);
        chk("full_level",    level,     138);
        step();
        in_valid = 1'b0;
        #1;
        chk("full_level_after_extra", level, 138);

        // ---- drain in order ----
        out_ready = 1'b1;
        for (int i = 0; i < 138; i++) begin
            w = 0;
            while (!out_valid && w < 8) begin
                step();
                w++;
            end
            bval = i[7:0];
            chk("drain_valid", out_valid, 1);
            chk("drain_data",  out_data,  bval);
            step();
        end
        step();
        chk("drain_empty_valid", out_valid, 0);
        chk("drain_empty_level", level,     0);
        chk("drain_hold_data",   out_data,  8'h89);

        // ---- continuous streaming across pointer wrap ----
        k_in    = 8'h00;
        exp_out = 8'h00;
        npop    = 0;
        npush   = 0;
        for (int c = 0; c < 300; c++) begin
            in_valid = 1'b1;
            in_data  = k_in;
            #1;
            pushed = in_ready;
            if (out_valid) begin
                chk("stream_data", out_data, exp_out);
                exp_out = exp_out + 8'd1;
                npop++;
            end
            step();
            if (pushed) begin
                k_in = k_in + 8'd1;
                npush++;
            end
        end
        in_valid = 1'b0;
        chk("stream_pushes", npush, 300);
        chk("stream_pops",   npop,  297);
        for (int j = 0; j < 3; j++) begin
            w = 0;
            while (!out_valid && w < 8) begin
                step();
                w++;
            end
            chk("stream_tail_valid", out_valid, 1);
            chk("stream_tail_data",  out_data,  exp_out);
            exp_out = exp_out + 8'd1;
            step();
        end
        chk("stream_end_valid", out_valid, 0);
        chk("stream_end_level", level,     0);

        // ---- reset mid-stream ----
        out_ready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            in_valid = 1'b1;
            bval     = 8'h40 + i[7:0];
            in_data  = bval;
            step();
        end
        chk("pre_rst_level", level, 50);
        in_data = 8'h77;
        rst_n   = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready,  0);
        chk("mid_rst_ena_a",    ram_ena_a, 0);
        chk("mid_rst_ena_b",    ram_ena_b, 0);
        step();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("post_rst_level", level,     0);
        chk("post_rst_valid", out_valid, 0);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        #1;
        chk("post_rst_adr_a", ram_adr_a, 0);
        chk("post_rst_ena_a", ram_ena_a, 1);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        w = 0;
        while (!out_valid && w < 8) begin
            step();
            w++;
        end
        chk("post_rst_first_valid", out_valid, 1);
        chk("post_rst_first_data",  out_data,  8'h3C);
        step();
        chk("post_rst_end_valid", out_valid, 0);
        chk("post_rst_end_level", level,     0);

`ifdef RAM2P_FIFO_AF_EN
        // ---- almost_full threshold at 128 ----
        out_ready = 1'b0;
        for (int i = 0; i < 127; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h5A;
            step();
        end
        in_valid = 1'b0;
        chk("af127_level", level,       127);
        chk("af127_flag",  almost_full, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("af128_level", level,       128);
        chk("af128_flag",  almost_full, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("af_pop_level", level,       127);
        chk("af_pop_flag",  almost_full, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("af_rst_flag", almost_full, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
